// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin 4:1 arbiter with hold limit and registered data mux
module mux_arbiter #(
    parameter int HOLD = 4
) (
    input  logic       c,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [1:0] s,
    output logic [3:0] gnt,
    output logic       y,
    output logic       y_vld
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] s_n;
    logic [3:0] gnt_n;
    logic       y_n, y_vld_n;
    logic [3:0] din;
    logic [2:0] pick_idle, pick_rel;

    // Returns {found, index}: first set bit scanning base, base+1, ... (mod 4).
    function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (r[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign din       = {in3, in2, in1, in0};
    assign pick_idle = rr_pick(ptr, req);
    assign pick_rel  = rr_pick(s + 2'd1, req);

    always_ff @(posedge c) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
            s     <= 2'd0;
            gnt   <= 4'd0;
            y     <= 1'b0;
            y_vld <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            s     <= s_n;
            gnt   <= gnt_n;
            y     <= y_n;
            y_vld <= y_vld_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        s_n     = s;
        gnt_n   = gnt;
        y_n     = y;
        y_vld_n = 1'b0;

        // Sample uses the owner as it stands before this edge's arbitration.
        if (state == GRANT && req[s]) begin
            y_n     = din[s];
            y_vld_n = 1'b1;
        end

        case (state)
            IDLE: begin
                gnt_n = 4'd0;
                if (pick_idle[2]) begin
                    state_n = GRANT;
                    s_n     = pick_idle[1:0];
                    gnt_n   = 4'b0001 << pick_idle[1:0];
                    cnt_n   = 4'd1;
                end
            end
            GRANT: begin
                if (!req[s] || cnt == 4'(HOLD)) begin
                    ptr_n = s + 2'd1;
                    if (pick_rel[2]) begin
                        s_n   = pick_rel[1:0];
                        gnt_n = 4'b0001 << pick_rel[1:0];
                        cnt_n = 4'd1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 4'd0;
                    end
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - randomized and directed bench for mux_arbiter against a behavioural model
module tb_mux_arbiter;

    localparam int HOLD = 4;

    logic       c = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       in0, in1, in2, in3;
    logic [1:0] s;
    logic [3:0] gnt;
    logic       y;
    logic       y_vld;

    int total = 0;
    int bad   = 0;

    // Behavioural model: owner index, busy flag, round-robin start, cycles held so far.
    bit m_busy;
    int m_own;
    int m_ptr;
    int m_held;
    bit m_y;
    bit m_vld;

    mux_arbiter #(.HOLD(HOLD)) dut (
        .c     (c),
        .rst   (rst),
        .req   (req),
        .in0   (in0),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .s     (s),
        .gnt   (gnt),
        .y     (y),
        .y_vld (y_vld)
    );

    always #5 c = ~c;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input int start, input logic [3:0] r);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    task automatic model_edge(input logic r_rst, input logic [3:0] r, input logic [3:0] d);
        int pick;
        if (r_rst) begin
            m_busy = 0; m_own = 0; m_ptr = 0; m_held = 0; m_y = 0; m_vld = 0;
            return;
        end
        if (m_busy && r[m_own]) begin
            m_y   = d[m_own];
            m_vld = 1;
        end else begin
            m_vld = 0;
        end
        if (!m_busy) begin
            pick = first_from(m_ptr, r);
            if (pick >= 0) begin
                m_busy = 1; m_own = pick; m_held = 1;
            end
        end else if (!r[m_own] || m_held == HOLD) begin
            m_ptr = (m_own + 1) % 4;
            pick  = first_from(m_ptr, r);
            if (pick >= 0) begin
                m_own = pick; m_held = 1;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_held++;
        end
    endtask

    // One clock: drive at the falling edge, let the DUT and model take the rising edge,
    // then compare at the next falling edge.
    task automatic step(input logic r_rst, input logic [3:0] r, input logic [3:0] d);
        int exp_gnt;
        rst = r_rst;
        req = r;
        {in3, in2, in1, in0} = d;
        @(posedge c);
        model_edge(r_rst, r, d);
        @(negedge c);
        exp_gnt = m_busy ? (1 << m_own) : 0;
        chk("gnt", int'(gnt), exp_gnt);
        chk("s", int'(s), m_own);
        chk("y_vld", int'(y_vld), int'(m_vld));
        chk("y", int'(y), int'(m_y));
        chk("gnt_onehot0", int'($onehot0(gnt)), 1);
    endtask

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        logic [3:0] rq;
        rst = 1'b1; req = 4'd0; {in3, in2, in1, in0} = 4'd0;
        m_busy = 0; m_own = 0; m_ptr = 0; m_held = 0; m_y = 0; m_vld = 0;
        @(negedge c);

        // reset state
        step(1'b1, 4'b0000, 4'b1111);
        chk("rst_s", int'(s), 0);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_y_vld", int'(y_vld), 0);

        // single requester, continuous: grant on edge 1, data on edge 2, re-grant with no gap
        step(1'b0, 4'b0001, 4'b0001);
        chk("single_e1_gnt", int'(gnt), 1);
        chk("single_e1_s", int'(s), 0);
        step(1'b0, 4'b0001, 4'b0001);
        chk("single_e2_y", int'(y), 1);
        chk("single_e2_vld", int'(y_vld), 1);
        for (int k = 3; k <= 9; k++) begin
            step(1'b0, 4'b0001, 4'b0001);
            chk("single_nogap_gnt", int'(gnt), 1);
        end

        // full contention: each requester HOLD cycles in rotation
        step(1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < 17; k++) begin
            step(1'b0, 4'b1111, rnd4());
            chk("contend_gnt", int'(gnt), 1 << ((k / HOLD) % 4));
        end

        // early drop of req[2]
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0100, 4'b0100);
        chk("drop_gnt_a", int'(gnt), 4);
        step(1'b0, 4'b0100, 4'b0100);
        chk("drop_gnt_b", int'(gnt), 4);
        step(1'b0, 4'b0000, 4'b0100);
        chk("drop_gnt_rel", int'(gnt), 0);
        chk("drop_s_held", int'(s), 2);
        chk("drop_vld", int'(y_vld), 0);

        // pointer wrap: owner 3 releases (ptr -> 0), then req=1001 grants 0 before 3
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b1000, 4'b0000);
        chk("wrap_own3", int'(gnt), 8);
        step(1'b0, 4'b0000, 4'b0000);
        chk("wrap_idle", int'(gnt), 0);
        step(1'b0, 4'b1001, 4'b1001);
        chk("wrap_first", int'(gnt), 1);
        for (int k = 0; k < HOLD - 1; k++) step(1'b0, 4'b1001, 4'b1001);
        step(1'b0, 4'b1001, 4'b1001);
        chk("wrap_second", int'(gnt), 8);

        // reset mid-grant
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0010, 4'b0010);
        step(1'b0, 4'b0010, 4'b0010);
        chk("midrst_pre", int'(gnt), 2);
        step(1'b1, 4'b0010, 4'b0010);
        chk("midrst_s", int'(s), 0);
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_y", int'(y), 0);
        chk("midrst_vld", int'(y_vld), 0);
        step(1'b0, 4'b1111, 4'b1111);
        chk("midrst_first", int'(gnt), 1);

        // random traffic with sticky requests and occasional reset
        rq = 4'd0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) rq = rnd4();
            if ($urandom_range(0, 9) == 0) rq[$urandom_range(0, 3)] = 1'b0;
            step(($urandom_range(0, 59) == 0), rq, rnd4());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
